// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, widths, op legality and response-slot states.
package alu_pkg;

    localparam int XLEN      = 32;
    localparam int ALU_CTR_W = 5;

    localparam logic [ALU_CTR_W-1:0] ALU_ADD   = 5'b00000;
    localparam logic [ALU_CTR_W-1:0] ALU_SUB   = 5'b00001;
    localparam logic [ALU_CTR_W-1:0] ALU_SLL   = 5'b00010;
    localparam logic [ALU_CTR_W-1:0] ALU_SLT   = 5'b00011;
    localparam logic [ALU_CTR_W-1:0] ALU_SLTU  = 5'b00100;
    localparam logic [ALU_CTR_W-1:0] ALU_XOR   = 5'b00101;
    localparam logic [ALU_CTR_W-1:0] ALU_SRL   = 5'b00110;
    localparam logic [ALU_CTR_W-1:0] ALU_SRA   = 5'b00111;
    localparam logic [ALU_CTR_W-1:0] ALU_OR    = 5'b01000;
    localparam logic [ALU_CTR_W-1:0] ALU_AND   = 5'b01001;
    localparam logic [ALU_CTR_W-1:0] ALU_ADDI  = 5'b01010;
    localparam logic [ALU_CTR_W-1:0] ALU_SLTI  = 5'b01011;
    localparam logic [ALU_CTR_W-1:0] ALU_SLTIU = 5'b01100;
    localparam logic [ALU_CTR_W-1:0] ALU_XORI  = 5'b01101;
    localparam logic [ALU_CTR_W-1:0] ALU_ORI   = 5'b01110;
    localparam logic [ALU_CTR_W-1:0] ALU_ANDI  = 5'b01111;
    localparam logic [ALU_CTR_W-1:0] ALU_SLLI  = 5'b10001;
    localparam logic [ALU_CTR_W-1:0] ALU_SRLI  = 5'b10010;
    localparam logic [ALU_CTR_W-1:0] ALU_SRAI  = 5'b10011;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } rsp_state_e;

    function automatic logic op_legal(input logic [ALU_CTR_W-1:0] op);
        return (op <= ALU_ANDI) || ((op >= ALU_SLLI) && (op <= ALU_SRAI));
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way grant: lock owner first, then fixed priority or round-robin on the `last` winner.
module rr_arb2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic [1:0] valid_i,
    input  logic       lock_vld_i,
    input  logic       lock_port_i,
    input  logic       update_i,
    input  logic       update_port_i,
    output logic [1:0] grant_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        last_d = last_q;
        if (update_i) begin
            last_d = update_port_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    // A held lock starves the other port even when the owner is idle.
    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            if (lock_vld_i) begin
                grant_o[lock_port_i] = valid_i[lock_port_i];
            end else if (valid_i == 2'b11) begin
                if (FIXED_PRIO) begin
                    grant_o = 2'b01;
                end else begin
                    grant_o = last_q ? 2'b01 : 2'b10;
                end
            end else begin
                grant_o = valid_i;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters and returns results
// through a one-entry registered response slot with backpressure.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int TAG_W      = 4,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [ALU_CTR_W-1:0] req0_op,
    input  logic [XLEN-1:0]      req0_a,
    input  logic [XLEN-1:0]      req0_b,
    input  logic                 req0_lock,
    input  logic [TAG_W-1:0]     req0_tag,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [ALU_CTR_W-1:0] req1_op,
    input  logic [XLEN-1:0]      req1_a,
    input  logic [XLEN-1:0]      req1_b,
    input  logic                 req1_lock,
    input  logic [TAG_W-1:0]     req1_tag,
    output logic [XLEN-1:0]      alu_a,
    output logic [XLEN-1:0]      alu_b,
    output logic [ALU_CTR_W-1:0] alu_ctr,
    input  logic [XLEN-1:0]      alu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_port,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic [XLEN-1:0]      rsp_result,
    output logic                 rsp_err
);

    rsp_state_e           state_q, state_d;
    logic                 rsp_port_q, rsp_port_d;
    logic [TAG_W-1:0]     rsp_tag_q, rsp_tag_d;
    logic [XLEN-1:0]      rsp_result_q, rsp_result_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 lock_vld_q, lock_vld_d;
    logic                 lock_port_q, lock_port_d;

    logic                 slot_free;
    logic                 arb_en;
    logic [1:0]           grant;
    logic                 accept;
    logic                 acc_port;
    logic [ALU_CTR_W-1:0] sel_op;
    logic [XLEN-1:0]      sel_a;
    logic [XLEN-1:0]      sel_b;
    logic                 sel_lock;
    logic [TAG_W-1:0]     sel_tag;
    logic                 sel_legal;

    // Gating with rst keeps both readies low during the reset cycle.
    assign slot_free = (state_q == S_EMPTY) || rsp_ready;
    assign arb_en    = slot_free && !rst;

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (arb_en),
        .valid_i       ({req1_valid, req0_valid}),
        .lock_vld_i    (lock_vld_q),
        .lock_port_i   (lock_port_q),
        .update_i      (accept),
        .update_port_i (acc_port),
        .grant_o       (grant)
    );

    assign accept     = |grant;
    assign acc_port   = grant[1];
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    assign sel_op    = acc_port ? req1_op   : req0_op;
    assign sel_a     = acc_port ? req1_a    : req0_a;
    assign sel_b     = acc_port ? req1_b    : req0_b;
    assign sel_lock  = acc_port ? req1_lock : req0_lock;
    assign sel_tag   = acc_port ? req1_tag  : req0_tag;
    assign sel_legal = op_legal(sel_op);

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_ctr = '0;
        if (accept) begin
            alu_a   = sel_a;
            alu_b   = sel_b;
            alu_ctr = sel_legal ? sel_op : ALU_ADD;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (accept) state_d = S_FULL;
            S_FULL:  if (rsp_ready && !accept) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        rsp_port_d   = rsp_port_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        lock_vld_d   = lock_vld_q;
        lock_port_d  = lock_port_q;
        if (accept) begin
            rsp_port_d   = acc_port;
            rsp_tag_d    = sel_tag;
            rsp_result_d = sel_legal ? alu_result : '0;
            rsp_err_d    = !sel_legal;
            if (sel_lock) begin
                lock_vld_d  = 1'b1;
                lock_port_d = acc_port;
            end else if (lock_vld_q && (lock_port_q == acc_port)) begin
                lock_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_EMPTY;
            rsp_port_q   <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            lock_vld_q   <= 1'b0;
            lock_port_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rsp_port_q   <= rsp_port_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            lock_vld_q   <= lock_vld_d;
            lock_port_q  <= lock_port_d;
        end
    end

    assign rsp_valid  = (state_q == S_FULL);
    assign rsp_port   = rsp_port_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a transaction-level reference model checked every cycle.
module tb_alu_arbiter;

    localparam int TAG_W      = 4;
    localparam bit FIXED_PRIO = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [4:0]  req0_op, req1_op, alu_ctr;
    logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_result;
    logic        req0_lock, req1_lock;
    logic [3:0]  req0_tag, req1_tag, rsp_tag;
    logic        rsp_valid, rsp_ready, rsp_port, rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.TAG_W(TAG_W), .FIXED_PRIO(FIXED_PRIO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_lock(req0_lock), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_lock(req1_lock), .req1_tag(req1_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_port(rsp_port),
        .rsp_tag(rsp_tag), .rsp_result(rsp_result), .rsp_err(rsp_err)
    );

    function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'd0, 5'd10:  return a + b;
            5'd1:         return a - b;
            5'd2, 5'd17:  return a << b[4:0];
            5'd3, 5'd11:  return {31'd0, $signed(a) < $signed(b)};
            5'd4, 5'd12:  return {31'd0, a < b};
            5'd5, 5'd13:  return a ^ b;
            5'd6, 5'd18:  return a >> b[4:0];
            5'd7, 5'd19:  return $unsigned($signed(a) >>> b[4:0]);
            5'd8, 5'd14:  return a | b;
            5'd9, 5'd15:  return a & b;
            default:      return 32'd0;
        endcase
    endfunction

    function automatic bit legal(input logic [4:0] op);
        return (op < 5'd16) || (op == 5'd17) || (op == 5'd18) || (op == 5'd19);
    endfunction

    assign alu_result = alu_ref(alu_ctr, alu_a, alu_b);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending response, lock owner (-1 none), last winner
    bit          model_on = 0;
    bit          m_valid;
    bit          m_port;
    logic [3:0]  m_tag;
    logic [31:0] m_result;
    bit          m_err;
    int          m_lock;
    int          m_last;
    int          exp_g = -1;

    always @(negedge clk) begin
        if (model_on) begin
            logic        v[2];
            logic [4:0]  op[2];
            logic [31:0] a[2], b[2];
            int          g;
            v[0] = req0_valid; v[1] = req1_valid;
            op[0] = req0_op;   op[1] = req1_op;
            a[0] = req0_a;     a[1] = req1_a;
            b[0] = req0_b;     b[1] = req1_b;
            g = -1;
            if (!rst && (!m_valid || rsp_ready)) begin
                if (m_lock >= 0) g = v[m_lock] ? m_lock : -1;
                else if (v[0] && v[1]) g = FIXED_PRIO ? 0 : 1 - m_last;
                else if (v[0]) g = 0;
                else if (v[1]) g = 1;
            end
            exp_g = g;
            chk("req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
            chk("req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
            chk("alu_a",   alu_a,   (g >= 0) ? a[g] : 32'd0);
            chk("alu_b",   alu_b,   (g >= 0) ? b[g] : 32'd0);
            chk("alu_ctr", {27'd0, alu_ctr}, (g >= 0 && legal(op[g])) ? {27'd0, op[g]} : 32'd0);
            chk("rsp_valid",  {31'd0, rsp_valid}, {31'd0, m_valid});
            chk("rsp_port",   {31'd0, rsp_port},  {31'd0, m_port});
            chk("rsp_tag",    {28'd0, rsp_tag},   {28'd0, m_tag});
            chk("rsp_result", rsp_result, m_result);
            chk("rsp_err",    {31'd0, rsp_err},   {31'd0, m_err});
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            model_on = 1;
            m_valid = 0; m_port = 0; m_tag = '0; m_result = '0; m_err = 0;
            m_lock = -1; m_last = 1; exp_g = -1;
        end else if (model_on) begin
            if (exp_g >= 0) begin
                logic [4:0]  op;
                logic [31:0] a, b;
                op = (exp_g == 1) ? req1_op : req0_op;
                a  = (exp_g == 1) ? req1_a  : req0_a;
                b  = (exp_g == 1) ? req1_b  : req0_b;
                m_valid  = 1;
                m_port   = (exp_g == 1);
                m_tag    = (exp_g == 1) ? req1_tag : req0_tag;
                m_err    = !legal(op);
                m_result = legal(op) ? alu_ref(op, a, b) : 32'd0;
                m_last   = exp_g;
                if ((exp_g == 1) ? req1_lock : req0_lock) m_lock = exp_g;
                else if (m_lock == exp_g) m_lock = -1;
            end else if (m_valid && rsp_ready) begin
                m_valid = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic lk, input logic [3:0] tg);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_lock = lk; req0_tag = tg;
    endtask

    task automatic set1(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic lk, input logic [3:0] tg);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_lock = lk; req1_tag = tg;
    endtask

    initial begin
        logic [3:0] alt_got;
        logic [3:0] alt_exp;
        rst = 1'b1;
        rsp_ready = 1'b0;
        set0(0, 5'd0, 0, 0, 0, 0);
        set1(0, 5'd0, 0, 0, 0, 0);
        repeat (2) tick();
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b0;

        // single ADD from port 0
        rsp_ready = 1'b1;
        set0(1, 5'b00000, 5, 7, 0, 4'd3);
        #1 chk("add_ready0", {31'd0, req0_ready}, 32'd1);
        tick();
        set0(0, 5'd0, 0, 0, 0, 0);
        #1;
        chk("add_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("add_result", rsp_result, 32'd12);
        chk("add_port", {31'd0, rsp_port}, 32'd0);
        chk("add_tag", {28'd0, rsp_tag}, 32'd3);
        tick();

        // both valid every cycle: last winner was port 0, so port 1 takes the first tie
        for (int i = 0; i < 4; i++) begin
            set0(1, 5'b00000, i, 100, 0, i[3:0]);
            set1(1, 5'b00001, 50, i, 0, 4'd8 + i[3:0]);
            #1 alt_got[i] = req1_ready;
            tick();
            if (i == 0) begin
                chk("alt_first_result", rsp_result, 32'd50);
                chk("alt_first_port", {31'd0, rsp_port}, 32'd1);
            end
        end
        alt_exp = 4'b0101;
        chk("alt_pattern", {28'd0, alt_got}, {28'd0, alt_exp});

        // backpressure: response held three cycles, no grants
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_ready0", {31'd0, req0_ready}, 32'd0);
            chk("hold_ready1", {31'd0, req1_ready}, 32'd0);
            chk("hold_result", rsp_result, 32'd103);
            tick();
        end
        rsp_ready = 1'b1;
        #1 chk("release_ready1", {31'd0, req1_ready}, 32'd1);
        tick();

        // lock held by port 1
        set0(0, 5'd0, 0, 0, 0, 0);
        set1(1, 5'b00001, 10, 3, 1, 4'd5);
        tick();
        set0(1, 5'b00000, 1, 1, 0, 4'd4);
        set1(0, 5'd0, 0, 0, 0, 0);
        #1 chk("lock_owner_idle_ready0", {31'd0, req0_ready}, 32'd0);
        tick();
        set1(1, 5'b00001, 10, 3, 0, 4'd6);
        #1;
        chk("lock_ready1", {31'd0, req1_ready}, 32'd1);
        chk("lock_ready0", {31'd0, req0_ready}, 32'd0);
        tick();
        chk("lock_result", rsp_result, 32'd7);
        chk("lock_port", {31'd0, rsp_port}, 32'd1);
        chk("unlock_ready0", {31'd0, req0_ready}, 32'd1);
        tick();

        // illegal op
        set1(0, 5'd0, 0, 0, 0, 0);
        set0(1, 5'b10100, 9, 9, 0, 4'd2);
        #1;
        chk("illegal_ready0", {31'd0, req0_ready}, 32'd1);
        chk("illegal_alu_ctr", {27'd0, alu_ctr}, 32'd0);
        tick();
        set0(0, 5'd0, 0, 0, 0, 0);
        #1;
        chk("illegal_err", {31'd0, rsp_err}, 32'd1);
        chk("illegal_result", rsp_result, 32'd0);
        tick();

        // reset with pending response and lock held
        rsp_ready = 1'b0;
        set1(1, 5'b00000, 2, 2, 1, 4'd1);
        tick();
        set0(1, 5'b00000, 6, 6, 0, 4'd7);
        set1(1, 5'b00000, 8, 8, 0, 4'd9);
        rst = 1'b1;
        #1;
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_rst_ready0", {31'd0, req0_ready}, 32'd1);
        tick();
        chk("post_rst_result", rsp_result, 32'd12);
        set0(0, 5'd0, 0, 0, 0, 0);
        set1(0, 5'd0, 0, 0, 0, 0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
